// File: rtl/axis_pkg.sv
// Shared AXI-Stream arbitration types, defaults and the round-robin selection helper.
// Used by axis_rr_arbiter (optional output register stage selected with AXIS_ARB_OUTREG_EN).
package axis_pkg;

    localparam int unsigned AXIS_DATA_W_DEF = 32;
    localparam int unsigned AXIS_MAX_SRC    = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } axis_arb_state_t;

    // First set bit of req searching ptr+1, ptr+2, ... modulo n; ptr itself is examined last.
    function automatic int unsigned rr_pick(
        input logic [AXIS_MAX_SRC-1:0] req,
        input int unsigned             ptr,
        input int unsigned             n
    );
        int unsigned sel;
        int unsigned idx;
        logic        found;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= AXIS_MAX_SRC; i++) begin
            idx = (ptr + i) % n;
            if (!found && (i <= n) && req[idx[3:0]]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/axis_skid.sv
// Two-entry skid buffer for the arbiter output stage (used when AXIS_ARB_OUTREG_EN is defined).
// Output valid/data and input ready are all taken straight from flops.
module axis_skid
    import axis_pkg::*;
#(
    parameter int unsigned W = AXIS_DATA_W_DEF + 1
) (
    input  logic         aclk,
    input  logic         areset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter sharing one AXI-Stream slave among N_SRC masters.
// Define AXIS_ARB_OUTREG_EN to drive m_* from a registered two-entry skid buffer.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter int unsigned N_SRC  = 4,
    parameter int unsigned DATA_W = AXIS_DATA_W_DEF
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [N_SRC-1:0]        s_tvalid,
    output logic [N_SRC-1:0]        s_tready,
    input  logic [N_SRC-1:0]        s_tlast,
    input  logic [N_SRC*DATA_W-1:0] s_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic [DATA_W-1:0]       m_tdata,
    output logic [N_SRC-1:0]        grant,
    output logic                    busy
);

    localparam int unsigned IDX_W = $clog2(N_SRC);

    axis_arb_state_t  state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick;
    logic [N_SRC-1:0] grant_next;
    logic             own_valid;
    logic             own_last;
    logic [DATA_W-1:0] own_data;
    logic             beat_taken;

    assign busy  = (state == LOCKED);
    assign pick  = IDX_W'(rr_pick(AXIS_MAX_SRC'(s_tvalid), 32'(rr_ptr), N_SRC));

    // rr_ptr is only updated on arbitration, so it doubles as the owner index while LOCKED.
    always_comb begin
        own_valid  = 1'b0;
        own_last   = 1'b0;
        own_data   = '0;
        grant_next = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (rr_ptr == IDX_W'(i)) begin
                own_valid = s_tvalid[i];
                own_last  = s_tlast[i];
                own_data  = s_tdata[i*DATA_W +: DATA_W];
            end
            grant_next[i] = (pick == IDX_W'(i));
        end
    end

`ifdef AXIS_ARB_OUTREG_EN
    logic              skid_in_ready;
    logic [DATA_W:0]   skid_out;

    assign beat_taken = busy && own_valid && skid_in_ready;
    assign s_tready   = grant & {N_SRC{skid_in_ready}};
    assign m_tlast    = skid_out[DATA_W];
    assign m_tdata    = skid_out[DATA_W-1:0];

    axis_skid #(
        .W (DATA_W + 1)
    ) u_skid (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .in_valid  (beat_taken),
        .in_ready  (skid_in_ready),
        .in_data   ({own_last, own_data}),
        .out_valid (m_tvalid),
        .out_ready (m_tready),
        .out_data  (skid_out)
    );
`else
    assign beat_taken = busy && own_valid && m_tready;
    assign s_tready   = grant & {N_SRC{m_tready}};
    assign m_tvalid   = busy && own_valid;
    assign m_tlast    = busy && own_last;
    assign m_tdata    = own_data;
`endif

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= IDX_W'(N_SRC - 1);
        end else if (state == IDLE) begin
            if (|s_tvalid) begin
                state  <= LOCKED;
                grant  <= grant_next;
                rr_ptr <= pick;
            end
        end else if (beat_taken && own_last) begin
            state <= IDLE;
            grant <= '0;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomised self-checking bench for axis_rr_arbiter against a packet-level arbitration model.
// Cycle-exact handshake checks apply to the default build; the stream scoreboard applies to both builds.
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            aclk = 1'b0;
    logic            areset_n = 1'b0;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N-1:0]    s_tlast;
    logic [N*DW-1:0] s_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [DW-1:0]   m_tdata;
    logic [N-1:0]    grant;
    logic            busy;

    axis_rr_arbiter #(
        .N_SRC  (N),
        .DATA_W (DW)
    ) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .s_tdata  (s_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .m_tdata  (m_tdata),
        .grant    (grant),
        .busy     (busy)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Source beats are {last, data}; data carries the source id in its top nibble.
    logic [DW:0] src_q [N][$];
    logic [DW:0] exp_q [N][$];
    int          pkt_log[$];
    bit          rand_gaps = 1'b0;
    bit          rand_ready = 1'b0;
    int          seq = 0;
    int          out_src = 0;
    bit          out_mid = 1'b0;

    // Arbitration model: idle/owned, owner, and last-granted pointer.
    bit mdl_locked = 1'b0;
    int mdl_owner = 0;
    int mdl_ptr = N - 1;

    task automatic add_packet(input int src, input int len);
        logic [DW:0] beat;
        for (int b = 0; b < len; b++) begin
            beat = {(b == len - 1), 4'(src), 28'(seq)};
            seq++;
            src_q[src].push_back(beat);
            exp_q[src].push_back(beat);
        end
    endtask

    task automatic drive_sources(input logic [N-1:0] acc);
        for (int i = 0; i < N; i++) begin
            bit hold;
            if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            hold = s_tvalid[i] && !acc[i];
            if (src_q[i].size() != 0) begin
                s_tvalid[i]          = hold || !rand_gaps || ($urandom_range(3) != 0);
                s_tlast[i]           = src_q[i][0][DW];
                s_tdata[i*DW +: DW]  = src_q[i][0][DW-1:0];
            end else begin
                s_tvalid[i]          = 1'b0;
                s_tlast[i]           = 1'b0;
                s_tdata[i*DW +: DW]  = '0;
            end
        end
        m_tready = !rand_ready || ($urandom_range(3) != 0);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++)
            if (exp_q[i].size() != 0 || src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Called at the falling edge; checks, advances the model, then moves to the next falling edge.
    task automatic step();
        logic [N-1:0] acc;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_rdy;
        bit           exp_mv;
        bit           found;
        int           src;
        exp_grant = '0;
        if (mdl_locked) exp_grant[mdl_owner] = 1'b1;
        exp_rdy = m_tready ? exp_grant : '0;
        exp_mv  = mdl_locked && s_tvalid[mdl_owner];
`ifndef AXIS_ARB_OUTREG_EN
        check("grant", grant, exp_grant);
        check("busy", busy, mdl_locked);
        check("s_tready", s_tready, exp_rdy);
        check("m_tvalid", m_tvalid, exp_mv);
        if (exp_mv) begin
            check("m_tdata", m_tdata, s_tdata[mdl_owner*DW +: DW]);
            check("m_tlast", m_tlast, s_tlast[mdl_owner]);
        end
`endif
        check("tready_outside_grant", s_tready & ~grant, '0);

        if (m_tvalid && m_tready) begin
            src = int'(m_tdata[DW-1:DW-4]);
            if (out_mid) check("packet_src_contiguous", src, out_src);
            else begin
                out_src = src;
                pkt_log.push_back(src);
            end
            check("beat_expected", (src < N) && (exp_q[src < N ? src : 0].size() != 0), 1'b1);
            if (src < N && exp_q[src].size() != 0)
                check("beat_data", {m_tlast, m_tdata}, exp_q[src].pop_front());
            out_mid = !m_tlast;
        end

        acc = s_tvalid & s_tready;
        if (!mdl_locked) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (mdl_ptr + k) % N;
                if (!found && s_tvalid[idx]) begin
                    found      = 1'b1;
                    mdl_locked = 1'b1;
                    mdl_owner  = idx;
                    mdl_ptr    = idx;
                end
            end
        end else if (s_tvalid[mdl_owner] && m_tready && s_tlast[mdl_owner]) begin
            mdl_locked = 1'b0;
        end

        @(posedge aclk);
        #1;
        drive_sources(acc);
        @(negedge aclk);
    endtask

    task automatic run_drain(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while (!all_empty() && cyc < budget) begin
            step();
            cyc++;
        end
        check({tag, "_drained"}, all_empty(), 1'b1);
        step();
        step();
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        s_tvalid   = '0;
        s_tlast    = '0;
        s_tdata    = '0;
        out_mid    = 1'b0;
        mdl_locked = 1'b0;
        mdl_owner  = 0;
        mdl_ptr    = N - 1;
    endtask

    task automatic apply_reset();
        areset_n = 1'b0;
        clear_all();
        @(negedge aclk);
        @(negedge aclk);
        areset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_all();
        m_tready = 1'b1;
        #1;
        check("reset_grant", grant, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_s_tready", s_tready, '0);
        check("reset_m_tvalid", m_tvalid, 1'b0);
        @(negedge aclk);
        areset_n = 1'b1;

        // Sources 0 and 2, two-beat packets, sink always ready.
        pkt_log.delete();
        add_packet(0, 2);
        add_packet(2, 2);
        drive_sources('0);
        run_drain("t1", 50);
        check("t1_npkts", pkt_log.size(), 2);
        if (pkt_log.size() == 2) begin
            check("t1_first_src", pkt_log[0], 0);
            check("t1_second_src", pkt_log[1], 2);
        end

        // All sources streaming single-beat packets back to back.
        apply_reset();
        pkt_log.delete();
        for (int r = 0; r < 5; r++)
            for (int i = 0; i < N; i++) add_packet(i, 1);
        drive_sources('0);
        run_drain("t2", 200);
        check("t2_npkts", pkt_log.size(), 5 * N);
        foreach (pkt_log[j]) check($sformatf("t2_order_%0d", j), pkt_log[j], j % N);

        // Random packets, gaps inside packets and downstream backpressure.
        rand_gaps  = 1'b1;
        rand_ready = 1'b1;
        for (int p = 0; p < 80; p++) add_packet($urandom_range(N - 1), $urandom_range(1, 5));
        drive_sources('0);
        run_drain("t3", 5000);
        rand_gaps  = 1'b0;
        rand_ready = 1'b0;

        // Reset pulsed between edges while source 1 is mid-packet.
        add_packet(1, 4);
        drive_sources('0);
        step();
        step();
        step();
        #2;
        areset_n = 1'b0;
        #1;
        check("midrst_grant", grant, '0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_s_tready", s_tready, '0);
        check("midrst_m_tvalid", m_tvalid, 1'b0);
        clear_all();
        @(negedge aclk);
        @(negedge aclk);
        areset_n = 1'b1;
        pkt_log.delete();
        add_packet(3, 1);
        add_packet(0, 2);
        add_packet(2, 1);
        drive_sources('0);
        run_drain("t5", 100);
        check("t5_npkts", pkt_log.size(), 3);
        if (pkt_log.size() == 3) begin
            check("t5_first_src", pkt_log[0], 0);
            check("t5_second_src", pkt_log[1], 2);
            check("t5_third_src", pkt_log[2], 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
